// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM controller: startup FSM encoding and response buffer sizing.
package ram_ctrl_pkg;

    localparam int RESP_DEPTH = 2;
    localparam int RESP_CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int RESP_PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ctrl_state_e;

    function automatic logic [RESP_PTR_W-1:0] nextPtr(input logic [RESP_PTR_W-1:0] ptr);
        return (ptr == RESP_PTR_W'(RESP_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/ram_ctrl_resp_buf.sv
// Small in-order response FIFO with valid/ready on both sides; output comes straight from storage
// so the head word stays stable while the consumer stalls.
module ram_ctrl_resp_buf
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RESP_CNT_W-1:0] count
);

    logic [DATA_WIDTH-1:0] slot_q [RESP_DEPTH];
    logic [RESP_PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [RESP_PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [RESP_CNT_W-1:0] count_q, count_d;
    logic                  push, pop;

    assign in_ready  = (count_q != RESP_CNT_W'(RESP_DEPTH));
    assign out_valid = (count_q != '0);
    assign out_data  = slot_q[rdPtr_q];
    assign count     = count_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wrPtr_d = push ? nextPtr(wrPtr_q) : wrPtr_q;
        rdPtr_d = pop ? nextPtr(rdPtr_q) : rdPtr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (push) begin
                slot_q[wrPtr_q] <= in_data;
            end
        end
    end

endmodule

// File: rtl/ram_ctrl.sv
// RAM controller: valid/ready front end to a single-port synchronous RAM with in-order read responses.
// Define RAM_CTRL_CLEAR_EN to zero the whole RAM after every reset before accepting traffic.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  mem_wr_rdn,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  init_done
);

    logic                  inFlight_q, inFlight_d;
    logic [ADDR_WIDTH-1:0] lastRdAddr_q, lastRdAddr_d;
    logic                  initDone_q;
    logic                  accept, rdAccept, wrAccept;
    logic                  bufInReady, bufPop;
    logic [RESP_CNT_W-1:0] bufCount;
    logic [RESP_CNT_W:0]   occupancy;
    logic                  rdSlotFree;
    logic                  clearing;
    logic [ADDR_WIDTH-1:0] clrAddr;

    // A response popped this cycle frees its slot now, which keeps back-to-back reads at full rate.
    assign occupancy  = {1'b0, bufCount} + {{RESP_CNT_W{1'b0}}, inFlight_q}
                      - {{RESP_CNT_W{1'b0}}, bufPop};
    assign rdSlotFree = occupancy < (RESP_CNT_W + 1)'(RESP_DEPTH);
    assign req_ready  = initDone_q && (req_we || rdSlotFree);
    assign accept     = req_valid && req_ready;
    assign rdAccept   = accept && !req_we;
    assign wrAccept   = accept && req_we;
    assign bufPop     = resp_valid && resp_ready;
    assign init_done  = initDone_q;

    assign inFlight_d   = rdAccept;
    assign lastRdAddr_d = rdAccept ? req_addr : lastRdAddr_q;

    always_comb begin
        mem_wr_rdn = wrAccept;
        mem_addr   = accept ? req_addr : lastRdAddr_q;
        mem_wdata  = req_wdata;
        if (clearing) begin
            mem_wr_rdn = 1'b1;
            mem_addr   = clrAddr;
            mem_wdata  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inFlight_q   <= 1'b0;
            lastRdAddr_q <= '0;
        end else begin
            inFlight_q   <= inFlight_d;
            lastRdAddr_q <= lastRdAddr_d;
        end
    end

`ifdef RAM_CTRL_CLEAR_EN
    ctrl_state_e           state_q;
    logic                  clrArm_q;
    logic [ADDR_WIDTH-1:0] clrAddr_q;

    // The arm flag keeps the write enable low while reset is held; the sweep begins one edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clrArm_q   <= 1'b0;
            clrAddr_q  <= '0;
            initDone_q <= 1'b0;
        end else begin
            clrArm_q <= 1'b1;
            if (state_q == ST_CLEAR) begin
                if (clrArm_q) begin
                    if (clrAddr_q == '1) begin
                        state_q    <= ST_RUN;
                        initDone_q <= 1'b1;
                    end else begin
                        clrAddr_q <= clrAddr_q + 1'b1;
                    end
                end
            end else begin
                initDone_q <= 1'b1;
            end
        end
    end

    assign clearing = (state_q == ST_CLEAR) && clrArm_q;
    assign clrAddr  = clrAddr_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            initDone_q <= 1'b0;
        end else begin
            initDone_q <= 1'b1;
        end
    end

    assign clearing = 1'b0;
    assign clrAddr  = '0;
`endif

    ram_ctrl_resp_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_resp_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (inFlight_q),
        .in_ready (bufInReady),
        .in_data  (mem_rdata),
        .out_valid(resp_valid),
        .out_ready(resp_ready),
        .out_data (resp_data),
        .count    (bufCount)
    );

    // Unused-ready guard: the slot accounting above guarantees room, so bufInReady is always high here.
    logic unusedOk;
    assign unusedOk = bufInReady;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: directed vector table, reset corner cases and a randomized run
// checked against a transaction-level model of the controller plus a behavioural RAM.
module tb_ram_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b0;
   logic          req_valid  = 1'b0;
   logic          req_we     = 1'b0;
   logic [AW-1:0] req_addr   = '0;
   logic [DW-1:0] req_wdata  = '0;
   logic          resp_ready = 1'b0;
   logic          req_ready;
   logic          resp_valid;
   logic [DW-1:0] resp_data;
   logic          mem_wr_rdn;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata  = '0;
   logic          init_done;

   ram_ctrl #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_data (resp_data),
      .mem_wr_rdn(mem_wr_rdn),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   // Downstream single-port RAM: address sampled on the edge, old data returned on a same-address write.
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (mem_wr_rdn) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   typedef struct {
      logic [DW-1:0] data;
      int            acc;
   } resp_t;

   typedef struct {
      logic          v;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          rr;
      logic          eReady;
      logic          eWr;
      logic          eRv;
      logic [DW-1:0] eRd;
   } vec_t;

   resp_t         expQ[$];
   logic [DW-1:0] shadow [DEPTH];
   logic [AW-1:0] lastRd;
   int            cycle;
   int            testsRun;
   int            testsFailed;
   vec_t          vecs [37];

   function automatic vec_t mkVec(input logic v, input logic we, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wdata, input logic rr, input logic eReady,
                                  input logic eWr, input logic eRv, input logic [DW-1:0] eRd);
      vec_t r;
      r.v = v; r.we = we; r.addr = addr; r.wdata = wdata; r.rr = rr;
      r.eReady = eReady; r.eWr = eWr; r.eRv = eRv; r.eRd = eRd;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // One clock cycle: drive after the edge, judge the settled outputs at the falling edge, then
   // advance the model. At most two reads may be outstanding; each read returns the memory
   // contents at its acceptance and becomes visible two cycles later, oldest first.
   task automatic applyStimulus(input logic v, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic rr);
      logic  expValid, pop, expReady, acc;
      resp_t r;
      @(posedge clk);
      #1;
      req_valid = v; req_we = we; req_addr = addr; req_wdata = wdata; resp_ready = rr;
      @(negedge clk);
      cycle++;
      expValid = (expQ.size() > 0) && (cycle >= expQ[0].acc + 2);
      pop      = expValid && rr;
      expReady = we || ((expQ.size() - int'(pop)) < 2);
      acc      = v && expReady;
      checkOutput("init_done", 32'(init_done), 32'd1);
      checkOutput("req_ready", 32'(req_ready), 32'(expReady));
      checkOutput("resp_valid", 32'(resp_valid), 32'(expValid));
      if (expValid) checkOutput("resp_data", 32'(resp_data), 32'(expQ[0].data));
      checkOutput("mem_wr_rdn", 32'(mem_wr_rdn), 32'(acc && we));
      checkOutput("mem_addr", 32'(mem_addr), acc ? 32'(addr) : 32'(lastRd));
      if (acc && we) checkOutput("mem_wdata", 32'(mem_wdata), 32'(wdata));
      if (pop) void'(expQ.pop_front());
      if (acc) begin
         if (we) begin
            shadow[addr] = wdata;
         end else begin
            r.data = shadow[addr];
            r.acc  = cycle;
            expQ.push_back(r);
            lastRd = addr;
         end
      end
   endtask

   task automatic assertReset(input int holdCycles);
      @(posedge clk);
      #1;
      rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h33; req_wdata = 8'hC3;
      resp_ready = 1'b0;
      #1;
      checkOutput("reset req_ready", 32'(req_ready), 32'd0);
      checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("reset resp_data", 32'(resp_data), 32'd0);
      checkOutput("reset mem_wr_rdn", 32'(mem_wr_rdn), 32'd0);
      checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("reset init_done", 32'(init_done), 32'd0);
      repeat (holdCycles) @(posedge clk);
      #1;
      rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b1;
      expQ.delete();
      lastRd = '0;
      #1;
      checkOutput("release init_done", 32'(init_done), 32'd0);
      checkOutput("release req_ready", 32'(req_ready), 32'd0);
   endtask

`ifdef RAM_CTRL_CLEAR_EN
   // Follows the zeroing sweep; stops early after stopAfter writes, otherwise expects a full sweep.
   task automatic runSweep(input int stopAfter);
      int nextAddr = 0;
      bit done     = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         if (init_done) begin
            done = 1'b1;
         end else if (mem_wr_rdn) begin
            checkOutput("sweep addr", 32'(mem_addr), 32'(nextAddr));
            checkOutput("sweep data", 32'(mem_wdata), 32'd0);
            nextAddr++;
            if (stopAfter > 0 && nextAddr == stopAfter) return;
         end
      end
      checkOutput("sweep count", 32'(nextAddr), 32'(DEPTH));
      checkOutput("sweep init_done", 32'(done), 32'd1);
      for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
   endtask
`endif

   task automatic doReset(input int holdCycles);
      assertReset(holdCycles);
`ifdef RAM_CTRL_CLEAR_EN
      runSweep(0);
`endif
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      cycle       = 0;
      lastRd      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ram[i]    = DW'(i + 'h40);
         shadow[i] = DW'(i + 'h40);
      end

      //                v  we addr   wdata  rr  rdy wr rv rdata
      vecs[0]  = mkVec(1, 1, 8'h01, 8'h41, 1,  1, 1, 0, 8'h00);
      vecs[1]  = mkVec(1, 1, 8'h02, 8'h42, 1,  1, 1, 0, 8'h00);
      vecs[2]  = mkVec(1, 1, 8'h03, 8'h43, 1,  1, 1, 0, 8'h00);
      vecs[3]  = mkVec(1, 1, 8'h05, 8'h45, 1,  1, 1, 0, 8'h00);
      vecs[4]  = mkVec(1, 1, 8'h06, 8'h46, 1,  1, 1, 0, 8'h00);
      vecs[5]  = mkVec(1, 1, 8'h10, 8'h5A, 1,  1, 1, 0, 8'h00);
      vecs[6]  = mkVec(1, 0, 8'h10, 8'h00, 1,  1, 0, 0, 8'h00);
      vecs[7]  = mkVec(0, 0, 8'h00, 8'h00, 1,  1, 0, 0, 8'h00);
      vecs[8]  = mkVec(0, 0, 8'h00, 8'h00, 1,  1, 0, 1, 8'h5A);
      vecs[9]  = mkVec(1, 0, 8'h01, 8'h00, 1,  1, 0, 0, 8'h00);
      vecs[10] = mkVec(1, 0, 8'h02, 8'h00, 1,  1, 0, 0, 8'h00);
      vecs[11] = mkVec(1, 0, 8'h03, 8'h00, 1,  1, 0, 1, 8'h41);
      vecs[12] = mkVec(0, 0, 8'h00, 8'h00, 1,  1, 0, 1, 8'h42);
      vecs[13] = mkVec(0, 0, 8'h00, 8'h00, 1,  1, 0, 1, 8'h43);
      vecs[14] = mkVec(0, 0, 8'h00, 8'h00, 1,  1, 0, 0, 8'h00);
      vecs[15] = mkVec(1, 0, 8'h01, 8'h00, 0,  1, 0, 0, 8'h00);
      vecs[16] = mkVec(1, 0, 8'h02, 8'h00, 0,  1, 0, 0, 8'h00);
      vecs[17] = mkVec(1, 0, 8'h03, 8'h00, 0,  0, 0, 1, 8'h41);
      vecs[18] = mkVec(1, 0, 8'h03, 8'h00, 0,  0, 0, 1, 8'h41);
      vecs[19] = mkVec(0, 0, 8'h00, 8'h00, 1,  1, 0, 1, 8'h41);
      vecs[20] = mkVec(0, 0, 8'h00, 8'h00, 1,  1, 0, 1, 8'h42);
      vecs[21] = mkVec(0, 0, 8'h00, 8'h00, 1,  1, 0, 0, 8'h00);
      vecs[22] = mkVec(1, 1, 8'h20, 8'h11, 1,  1, 1, 0, 8'h00);
      vecs[23] = mkVec(1, 0, 8'h20, 8'h00, 1,  1, 0, 0, 8'h00);
      vecs[24] = mkVec(1, 1, 8'h20, 8'h22, 1,  1, 1, 0, 8'h00);
      vecs[25] = mkVec(0, 0, 8'h00, 8'h00, 1,  1, 0, 1, 8'h11);
      vecs[26] = mkVec(1, 0, 8'h20, 8'h00, 1,  1, 0, 0, 8'h00);
      vecs[27] = mkVec(0, 0, 8'h00, 8'h00, 1,  1, 0, 0, 8'h00);
      vecs[28] = mkVec(0, 0, 8'h00, 8'h00, 1,  1, 0, 1, 8'h22);
      vecs[29] = mkVec(0, 0, 8'h00, 8'h00, 1,  1, 0, 0, 8'h00);
      vecs[30] = mkVec(1, 0, 8'h05, 8'h00, 0,  1, 0, 0, 8'h00);
      vecs[31] = mkVec(1, 0, 8'h06, 8'h00, 0,  1, 0, 0, 8'h00);
      vecs[32] = mkVec(1, 1, 8'h07, 8'h77, 0,  1, 1, 1, 8'h45);
      vecs[33] = mkVec(1, 0, 8'h07, 8'h00, 0,  0, 0, 1, 8'h45);
      vecs[34] = mkVec(0, 0, 8'h00, 8'h00, 1,  1, 0, 1, 8'h45);
      vecs[35] = mkVec(0, 0, 8'h00, 8'h00, 1,  1, 0, 1, 8'h46);
      vecs[36] = mkVec(0, 0, 8'h00, 8'h00, 1,  1, 0, 0, 8'h00);

      doReset(2);

      for (int i = 0; i < 37; i++) begin
         applyStimulus(vecs[i].v, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rr);
         checkOutput($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].eReady));
         checkOutput($sformatf("vec%0d mem_wr_rdn", i), 32'(mem_wr_rdn), 32'(vecs[i].eWr));
         checkOutput($sformatf("vec%0d resp_valid", i), 32'(resp_valid), 32'(vecs[i].eRv));
         if (vecs[i].eRv) checkOutput($sformatf("vec%0d resp_data", i), 32'(resp_data), 32'(vecs[i].eRd));
      end

      // Reset right after a read is accepted, with an older response still buffered.
      applyStimulus(1, 0, 8'h10, 8'h00, 0);
      applyStimulus(0, 0, 8'h00, 8'h00, 0);
      applyStimulus(0, 0, 8'h00, 8'h00, 0);
      applyStimulus(1, 0, 8'h03, 8'h00, 0);
      doReset(1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 0, 8'h00, 8'h00, 1);
         checkOutput("post-reset no response", 32'(resp_valid), 32'd0);
      end

      // Memory contents survive reset.
      applyStimulus(1, 0, 8'h20, 8'h00, 1);
      applyStimulus(0, 0, 8'h00, 8'h00, 1);
      applyStimulus(0, 0, 8'h00, 8'h00, 1);

      for (int n = 0; n < 400; n++) begin
         if (n == 200) doReset(2);
         applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 3),
                       AW'($urandom_range(0, 15)), DW'($urandom), ($urandom_range(0, 9) < 6));
      end
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 8'h00, 1);

`ifdef RAM_CTRL_CLEAR_EN
      // Interrupt the sweep at address 0x80; the next sweep must start over from zero.
      assertReset(1);
      runSweep(8'h80 + 1);
      assertReset(1);
      runSweep(0);
      applyStimulus(1, 0, 8'hFF, 8'h00, 1);
      applyStimulus(0, 0, 8'h00, 8'h00, 1);
      applyStimulus(0, 0, 8'h00, 8'h00, 1);
      checkOutput("cleared 0xFF resp_data", 32'(resp_data), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
